mac_array_engine: RTL and testbench



---
 rtl/mac_array_engine.sv | 183 ++++++++++++++++++
 tb/tb_mac_array_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_engine.sv
// Precision-scalable MAC engine: CHANNELS 8-bit lanes split into 1/2/4 sub-word products,
// one registered operand stage feeding CHANNELS*4 wrap-around sub-lane accumulators.
module mac_array_engine #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 24,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  input  logic [CNT_W-1:0]            batch_len,
  input  logic [1:0]                  mode,
  input  logic                        sx,
  input  logic                        sy,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*8-1:0]       act,
  input  logic [CHANNELS*8-1:0]       wgt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*4*ACC_W-1:0] out_data,
  output logic                        busy
);
  localparam int LANES = CHANNELS * 4;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      len_q;
  logic [1:0]            mode_q;
  logic                  sx_q;
  logic                  sy_q;
  logic                  s1_tag_q;
  logic [CHANNELS*8-1:0] s1_act_q;
  logic [CHANNELS*8-1:0] s1_wgt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic                  acc_clr;
  logic                  acc_en;

  assign cnt_d     = cnt_q + CNT_W'(1);
  assign acc_clr   = (state_q == IDLE) && start && !clr;
  assign acc_en    = s1_tag_q && !clr;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      s1_tag_q    <= 1'b0;
      s1_act_q    <= '0;
      s1_wgt_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      s1_tag_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Stage-1 returns to zero unless a beat transfers this cycle.
      s1_tag_q <= 1'b0;
      s1_act_q <= '0;
      s1_wgt_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q  <= '0;
            len_q  <= batch_len;
            mode_q <= mode;
            sx_q   <= sx;
            sy_q   <= sy;
            busy_q <= 1'b1;
            if (batch_len != '0) begin
              state_q    <= BUSY;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (in_valid) begin
            s1_tag_q <= 1'b1;
            s1_act_q <= act;
            s1_wgt_q <= wgt;
            cnt_q    <= cnt_d;
            if (cnt_d == len_q) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Lane gi is sub-lane gi%4 of channel gi/4; each field is widened to its product width
  // with one extension bit, so the truncated product is the exact signed result.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int C = gi / 4;
    localparam int K = gi % 4;

    logic [5:0]        a2;
    logic [5:0]        w2;
    logic signed [5:0] p2;
    logic signed [9:0] p4;
    logic signed [17:0] p8;
    logic [ACC_W-1:0]  lane_prod;
    logic [ACC_W-1:0]  acc_q;

    assign a2 = {{4{sx_q & s1_act_q[8*C+2*K+1]}}, s1_act_q[8*C+2*K +: 2]};
    assign w2 = {{4{sy_q & s1_wgt_q[8*C+2*K+1]}}, s1_wgt_q[8*C+2*K +: 2]};
    assign p2 = a2 * w2;

    if (K < 2) begin : g_nib
      logic [9:0] a4;
      logic [9:0] w4;
      assign a4 = {{6{sx_q & s1_act_q[8*C+4*K+3]}}, s1_act_q[8*C+4*K +: 4]};
      assign w4 = {{6{sy_q & s1_wgt_q[8*C+4*K+3]}}, s1_wgt_q[8*C+4*K +: 4]};
      assign p4 = a4 * w4;
    end else begin : g_no_nib
      assign p4 = '0;
    end

    if (K == 0) begin : g_byte
      logic [17:0] a8;
      logic [17:0] w8;
      assign a8 = {{10{sx_q & s1_act_q[8*C+7]}}, s1_act_q[8*C +: 8]};
      assign w8 = {{10{sy_q & s1_wgt_q[8*C+7]}}, s1_wgt_q[8*C +: 8]};
      assign p8 = a8 * w8;
    end else begin : g_no_byte
      assign p8 = '0;
    end

    always_comb begin
      lane_prod = '0;
      case (mode_q)
        2'b00:   lane_prod = ACC_W'(p2);
        2'b01:   lane_prod = ACC_W'(p4);
        default: lane_prod = ACC_W'(p8);
      endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        acc_q <= '0;
      end else if (acc_clr) begin
        acc_q <= '0;
      end else if (acc_en) begin
        acc_q <= acc_q + lane_prod;
      end
    end

    assign out_data[gi*ACC_W +: ACC_W] = acc_q;
  end

endmodule

// File: tb/tb_mac_array_engine.sv
// Randomised bench for mac_array_engine; expected sums come from a per-field integer model.
module tb_mac_array_engine;
  localparam int CH = 4;
  localparam int AW = 18;
  localparam int CW = 8;
  localparam int DW = CH * 4 * AW;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [CW-1:0] batch_len;
  logic [1:0]    mode;
  logic          sx;
  logic          sy;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [CH*8-1:0] act;
  logic [CH*8-1:0] wgt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CH*8-1:0] beat_act[$];
  logic [CH*8-1:0] beat_wgt[$];

  mac_array_engine #(.CHANNELS(CH), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .nrst(nrst), .start(start), .batch_len(batch_len), .mode(mode),
    .sx(sx), .sy(sy), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .wgt(wgt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dot products over the queued beats, field by field, with plain integer arithmetic.
  function automatic logic [DW-1:0] model(input logic [1:0] m, input logic sxm, input logic sym);
    longint acc[CH*4];
    logic [DW-1:0] r;
    int fw, nl, half, av, wv;
    fw   = (m == 2'b00) ? 2 : (m == 2'b01) ? 4 : 8;
    nl   = 8 / fw;
    half = 1 << (fw - 1);
    foreach (acc[i]) acc[i] = 0;
    foreach (beat_act[b]) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < nl; k++) begin
          av = (int'(beat_act[b][8*c +: 8]) >> (fw * k)) & ((1 << fw) - 1);
          wv = (int'(beat_wgt[b][8*c +: 8]) >> (fw * k)) & ((1 << fw) - 1);
          if (sxm && av >= half) av -= 2 * half;
          if (sym && wv >= half) wv -= 2 * half;
          acc[c*4+k] += longint'(av * wv);
        end
      end
    end
    r = '0;
    for (int i = 0; i < CH * 4; i++) r[i*AW +: AW] = acc[i][AW-1:0];
    return r;
  endfunction

  // Starts a batch of the queued beats and feeds them; cycle 0 is the start cycle.
  task automatic run_batch(input logic [1:0] m, input logic sxv, input logic syv,
                           input int gap, input bit extra,
                           output int accepted, output int first_c, output int last_c,
                           output int ov_c, output logic rdy_s1);
    int n, idx, cyc;
    bit xfer;
    n = beat_act.size();
    start = 1'b1; batch_len = CW'(n); mode = m; sx = sxv; sy = syv;
    tick();
    start = 1'b0;
    batch_len = CW'($urandom); mode = 2'($urandom); sx = 1'($urandom); sy = 1'($urandom);
    rdy_s1 = in_ready;
    accepted = 0; idx = 0; cyc = 1; first_c = -1; last_c = -1; ov_c = -1;
    while (cyc < 1000) begin
      if (out_valid === 1'b1) begin
        ov_c = cyc;
        break;
      end
      if (idx < n) begin
        in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
        act = beat_act[idx];
        wgt = beat_wgt[idx];
      end else begin
        in_valid = extra ? 1'(cyc % 2) : 1'b0;
        act = $urandom;
        wgt = $urandom;
      end
      xfer = (in_valid === 1'b1) && (in_ready === 1'b1);
      tick();
      if (xfer) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        accepted++;
        if (idx < n) idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic fill_random(input int n);
    beat_act.delete();
    beat_wgt.delete();
    for (int i = 0; i < n; i++) begin
      beat_act.push_back($urandom);
      beat_wgt.push_back($urandom);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_8b_signed();
    int acc_n, f, l, o;
    logic r1;
    logic [CH*8-1:0] a, w;
    logic [DW-1:0] exp;
    beat_act.delete(); beat_wgt.delete();
    for (int i = 0; i < 4; i++) begin
      a = $urandom; w = $urandom;
      a[7:0] = 8'hFD; w[7:0] = 8'h05;
      beat_act.push_back(a); beat_wgt.push_back(w);
    end
    exp = model(2'b10, 1'b1, 1'b1);
    run_batch(2'b10, 1'b1, 1'b1, 0, 1'b0, acc_n, f, l, o, r1);
    n_checks++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL 8b_ready_after_start: got %b required 1", r1); end
    n_checks++; if (f != 1 || l != 4) begin n_fail++; $display("FAIL 8b_throughput: got beats in cycles %0d..%0d required 1..4", f, l); end
    n_checks++; if (o - l != 2) begin n_fail++; $display("FAIL 8b_latency: got %0d required 2", o - l); end
    n_checks++; if (out_data[AW-1:0] !== 18'h3FFC4) begin n_fail++; $display("FAIL 8b_lane0: got %h required 3ffc4", out_data[AW-1:0]); end
    n_checks++; if (out_data[4*AW-1:AW] !== '0) begin n_fail++; $display("FAIL 8b_lanes1_3: got %h required 0", out_data[4*AW-1:AW]); end
    n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL 8b_all_lanes: got %h required %h", out_data, exp); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL 8b_busy_done: got %b required 1", busy); end
    release_result();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL 8b_release: got valid %b busy %b required 0 0", out_valid, busy); end
  endtask

  task automatic test_4b_unsigned();
    int acc_n, f, l, o;
    logic r1;
    logic [CH*8-1:0] a, w;
    logic [DW-1:0] exp, snap;
    beat_act.delete(); beat_wgt.delete();
    for (int i = 0; i < 3; i++) begin
      a = $urandom; w = $urandom;
      a[7:0] = 8'h21; w[7:0] = 8'h43;
      beat_act.push_back(a); beat_wgt.push_back(w);
    end
    exp = model(2'b01, 1'b0, 1'b0);
    run_batch(2'b01, 1'b0, 1'b0, 0, 1'b0, acc_n, f, l, o, r1);
    n_checks++; if (out_data[2*AW-1:0] !== {18'd24, 18'd9}) begin n_fail++; $display("FAIL 4b_lanes0_1: got %h required lane1=24 lane0=9", out_data[2*AW-1:0]); end
    n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL 4b_all_lanes: got %h required %h", out_data, exp); end
    // A start pulse while the result is waiting must not disturb it.
    snap = out_data;
    start = 1'b1; batch_len = 8'd3;
    tick();
    start = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== snap) begin n_fail++; $display("FAIL start_in_done: got valid %b ready %b data %h required 1 0 %h", out_valid, in_ready, out_data, snap); end
    release_result();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL 4b_release: got valid %b busy %b required 0 0", out_valid, busy); end
  endtask

  task automatic test_2b_signed();
    int acc_n, f, l, o;
    logic r1;
    logic [CH*8-1:0] a, w;
    logic [DW-1:0] exp;
    beat_act.delete(); beat_wgt.delete();
    for (int i = 0; i < 2; i++) begin
      a = $urandom; w = $urandom;
      a[7:0] = 8'hFF; w[7:0] = 8'h55;
      beat_act.push_back(a); beat_wgt.push_back(w);
    end
    exp = model(2'b00, 1'b1, 1'b1);
    run_batch(2'b00, 1'b1, 1'b1, 0, 1'b0, acc_n, f, l, o, r1);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_data[k*AW +: AW] !== 18'h3FFFE) begin n_fail++; $display("FAIL 2b_lane%0d: got %h required 3fffe", k, out_data[k*AW +: AW]); end
    end
    n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL 2b_all_lanes: got %h required %h", out_data, exp); end
    release_result();
  endtask

  task automatic test_wrap_backpressure();
    int acc_n, f, l, o;
    logic r1;
    logic [DW-1:0] exp, snap;
    bit held;
    beat_act.delete(); beat_wgt.delete();
    for (int i = 0; i < 5; i++) begin
      beat_act.push_back('1); beat_wgt.push_back('1);
    end
    exp = model(2'b10, 1'b0, 1'b0);
    run_batch(2'b10, 1'b0, 1'b0, 1, 1'b1, acc_n, f, l, o, r1);
    n_checks++; if (acc_n != 5) begin n_fail++; $display("FAIL wrap_beats_accepted: got %0d required 5", acc_n); end
    n_checks++; if (o - l != 2) begin n_fail++; $display("FAIL wrap_latency: got %0d required 2", o - l); end
    n_checks++; if (out_data[AW-1:0] !== 18'h0F605) begin n_fail++; $display("FAIL wrap_lane0: got %h required 0f605", out_data[AW-1:0]); end
    n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL wrap_all_lanes: got %h required %h", out_data, exp); end
    snap = out_data;
    held = 1'b1;
    repeat (3) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== snap) held = 1'b0;
    end
    n_checks++; if (!held) begin n_fail++; $display("FAIL wrap_hold: got valid %b data %h required 1 %h", out_valid, out_data, snap); end
    release_result();
    n_checks++; if (out_valid !== 1'b0 || out_data !== snap) begin n_fail++; $display("FAIL wrap_after_release: got valid %b data %h required 0 %h", out_valid, out_data, snap); end
  endtask

  task automatic test_zero_len();
    start = 1'b1; batch_len = '0; mode = 2'b10;
    tick();
    start = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_len_valid: got valid %b ready %b required 1 0", out_valid, in_ready); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL zero_len_data: got %h required 0", out_data); end
    release_result();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_len_release: got %b required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int acc_n, f, l, o;
    logic r1;
    logic [1:0] m;
    logic sxv, syv;
    logic [DW-1:0] exp;
    for (int t = 0; t < 2; t++) begin
      m = 2'($urandom); sxv = 1'($urandom); syv = 1'($urandom);
      fill_random(3 + t);
      exp = model(m, sxv, syv);
      run_batch(m, sxv, syv, 0, 1'b0, acc_n, f, l, o, r1);
      n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL back_to_back_%0d: got %h required %h", t, out_data, exp); end
      release_result();
    end
  endtask

  task automatic test_clr_abort();
    logic [1:0] m;
    logic [DW-1:0] exp;
    bit stayed;
    m = 2'($urandom);
    fill_random(4);
    start = 1'b1; batch_len = 8'd4; mode = m; sx = 1'b1; sy = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; act = beat_act[i]; wgt = beat_wgt[i];
      tick();
    end
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    // Only the first beat reached the accumulators; the staged second one is discarded.
    beat_act = beat_act[0:0];
    beat_wgt = beat_wgt[0:0];
    exp = model(m, 1'b1, 1'b0);
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_idle: got busy %b ready %b valid %b required 0 0 0", busy, in_ready, out_valid); end
    n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL clr_acc_untouched: got %h required %h", out_data, exp); end
    stayed = 1'b1;
    repeat (4) begin
      in_valid = 1'b1;
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) stayed = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++; if (!stayed) begin n_fail++; $display("FAIL clr_stays_idle: got valid %b busy %b required 0 0", out_valid, busy); end
    start = 1'b1; clr = 1'b1; batch_len = 8'd3;
    tick();
    start = 1'b0; clr = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_beats_start: got busy %b ready %b required 0 0", busy, in_ready); end
  endtask

  task automatic test_reset_midbusy();
    int acc_n, f, l, o;
    logic r1;
    logic [DW-1:0] exp;
    fill_random(5);
    start = 1'b1; batch_len = 8'd5; mode = 2'b10; sx = 1'b0; sy = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; act = beat_act[i]; wgt = beat_wgt[i];
      tick();
    end
    #2 nrst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctrl: got ready %b valid %b busy %b required 0 0 0", in_ready, out_valid, busy); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL async_reset_data: got %h required 0", out_data); end
    in_valid = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    fill_random(6);
    exp = model(2'b01, 1'b1, 1'b1);
    run_batch(2'b01, 1'b1, 1'b1, 2, 1'b0, acc_n, f, l, o, r1);
    n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL after_reset_batch: got %h required %h", out_data, exp); end
    release_result();
  endtask

  task automatic test_random();
    int acc_n, f, l, o, n;
    logic r1;
    logic [1:0] m;
    logic sxv, syv;
    logic [DW-1:0] exp;
    for (int t = 0; t < 8; t++) begin
      m = 2'($urandom); sxv = 1'($urandom); syv = 1'($urandom);
      n = $urandom_range(1, 12);
      fill_random(n);
      exp = model(m, sxv, syv);
      run_batch(m, sxv, syv, 2, 1'($urandom_range(0, 1)), acc_n, f, l, o, r1);
      n_checks++; if (acc_n != n) begin n_fail++; $display("FAIL rand%0d_beats: got %0d required %0d", t, acc_n, n); end
      n_checks++; if (o - l != 2) begin n_fail++; $display("FAIL rand%0d_latency: got %0d required 2", t, o - l); end
      n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL rand%0d_data: mode %0d sx %b sy %b got %h required %h", t, m, sxv, syv, out_data, exp); end
      repeat ($urandom_range(0, 2)) tick();
      release_result();
    end
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; batch_len = '0; mode = '0; sx = 1'b0; sy = 1'b0;
    clr = 1'b0; in_valid = 1'b0; act = '0; wgt = '0; out_ready = 1'b0;
    test_reset();
    test_8b_signed();
    test_4b_unsigned();
    test_2b_signed();
    test_wrap_backpressure();
    test_zero_len();
    test_back_to_back();
    test_clr_abort();
    test_reset_midbusy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
